// File: rtl/noc_ep_pkg.sv
// rtl/noc_ep_pkg.sv - shared types and helpers for the multi-channel NoC endpoint
package noc_ep_pkg;

  localparam int FLIT_DATA_W = 64;
  localparam int FLIT_DEST_W = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic [FLIT_DEST_W-1:0] dest;
    logic                   tail;
  } flit_t;

  // Channel addressed by a flit: low bits of the tid field sitting above tdest.
  function automatic int chan_of(input logic [FLIT_DEST_W-1:0] dest,
                                 input int tdest_width,
                                 input int num_channels);
    int v;
    v = int'(dest >> tdest_width);
    return v % num_channels;
  endfunction

endpackage

// File: rtl/noc_ep_flit_fifo.sv
// rtl/noc_ep_flit_fifo.sv - synchronous flit FIFO with simultaneous push/pop and sticky overflow
module noc_ep_flit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_noc_multi_endpoint.sv
// rtl/axis_noc_multi_endpoint.sv - multi-channel AXIS endpoint on router port 0; NOC_EP_PERF_CNT_EN adds per-channel flit counters
module axis_noc_multi_endpoint
  import noc_ep_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int TDATA_WIDTH       = 64,
  parameter int TID_WIDTH         = 2,
  parameter int TDEST_WIDTH       = 2,
  parameter int DEST_WIDTH        = TID_WIDTH + TDEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                                      clk_noc,
  input  logic                                      rst_n,
  input  logic [0:NUM_CHANNELS-1]                   axis_in_tvalid,
  output logic [0:NUM_CHANNELS-1]                   axis_in_tready,
  input  logic [0:NUM_CHANNELS-1][TDATA_WIDTH-1:0]  axis_in_tdata,
  input  logic [0:NUM_CHANNELS-1]                   axis_in_tlast,
  input  logic [0:NUM_CHANNELS-1][TID_WIDTH-1:0]    axis_in_tid,
  input  logic [0:NUM_CHANNELS-1][TDEST_WIDTH-1:0]  axis_in_tdest,
  output logic [0:NUM_CHANNELS-1]                   axis_out_tvalid,
  input  logic [0:NUM_CHANNELS-1]                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                    axis_out_tdata,
  output logic                                      axis_out_tlast,
  output logic [TID_WIDTH-1:0]                      axis_out_tid,
  output logic [TDEST_WIDTH-1:0]                    axis_out_tdest,
  output logic [TDATA_WIDTH-1:0]                    data_out,
  output logic [DEST_WIDTH-1:0]                     dest_out,
  output logic                                      is_tail_out,
  output logic                                      send_out,
  input  logic                                      credit_in,
  input  logic [TDATA_WIDTH-1:0]                    data_in,
  input  logic [DEST_WIDTH-1:0]                     dest_in,
  input  logic                                      is_tail_in,
  input  logic                                      send_in,
  output logic                                      credit_out,
  output logic                                      err_credit_overflow,
  output logic                                      err_eject_overflow
`ifdef NOC_EP_PERF_CNT_EN
  ,
  output logic [0:NUM_CHANNELS-1][31:0]             perf_inj_flits,
  output logic [0:NUM_CHANNELS-1][31:0]             perf_ej_flits
`endif
);

  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int CRW = $clog2(FLIT_BUFFER_DEPTH + 1);

  arb_state_e     state_q, state_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d, grant_ch;
  logic           grant_valid, xfer, grant_last;
  logic [CRW-1:0] credits_q;
  logic           credit_ok;

  function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
    return CHW'((int'(c) + 1) % NUM_CHANNELS);
  endfunction

  assign credit_ok  = (credits_q != '0);
  assign grant_last = axis_in_tlast[grant_ch];
  assign xfer       = grant_valid & axis_in_tvalid[grant_ch] & credit_ok;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    int idx;
    grant_ch    = lock_ch_q;
    grant_valid = 1'b0;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    idx         = 0;
    case (state_q)
      IDLE: begin
        // Scan from the farthest offset down so the nearest valid channel wins.
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
          idx = (int'(rr_ptr_q) + i) % NUM_CHANNELS;
          if (axis_in_tvalid[idx]) begin
            grant_ch    = CHW'(idx);
            grant_valid = 1'b1;
          end
        end
        if (grant_valid) begin
          if (xfer && grant_last) begin
            rr_ptr_d = next_ch(grant_ch);
          end else begin
            state_d   = LOCKED;
            lock_ch_d = grant_ch;
          end
        end
      end
      LOCKED: begin
        grant_valid = 1'b1;
        if (xfer && grant_last) begin
          state_d  = IDLE;
          rr_ptr_d = next_ch(lock_ch_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      axis_in_tready[c] = rst_n & grant_valid & (grant_ch == CHW'(c)) & credit_ok;
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= xfer;
      if (xfer) begin
        data_out    <= axis_in_tdata[grant_ch];
        dest_out    <= {axis_in_tid[grant_ch], axis_in_tdest[grant_ch]};
        is_tail_out <= grant_last;
      end
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credits_q           <= CRW'(FLIT_BUFFER_DEPTH);
      err_credit_overflow <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10: credits_q <= credits_q - 1'b1;
        2'b01: begin
          if (credits_q == CRW'(FLIT_BUFFER_DEPTH)) err_credit_overflow <= 1'b1;
          else credits_q <= credits_q + 1'b1;
        end
        default: credits_q <= credits_q;
      endcase
    end
  end

  flit_t          push_flit, head_flit;
  logic           ej_empty, ej_pop;
  logic [CHW-1:0] head_ch;

  always_comb begin
    push_flit      = '0;
    push_flit.data = FLIT_DATA_W'(data_in);
    push_flit.dest = FLIT_DEST_W'(dest_in);
    push_flit.tail = is_tail_in;
  end

  noc_ep_flit_fifo #(
    .DEPTH (FLIT_BUFFER_DEPTH),
    .WIDTH ($bits(flit_t))
  ) u_eject_fifo (
    .clk       (clk_noc),
    .rst_n     (rst_n),
    .push      (send_in),
    .push_data (push_flit),
    .pop       (ej_pop),
    .head_data (head_flit),
    .empty     (ej_empty),
    .overflow  (err_eject_overflow)
  );

  assign head_ch        = CHW'(chan_of(head_flit.dest, TDEST_WIDTH, NUM_CHANNELS));
  assign ej_pop         = ~ej_empty & axis_out_tready[head_ch];
  assign axis_out_tdata = head_flit.data[TDATA_WIDTH-1:0];
  assign axis_out_tlast = head_flit.tail;
  assign axis_out_tid   = head_flit.dest[DEST_WIDTH-1:TDEST_WIDTH];
  assign axis_out_tdest = head_flit.dest[TDEST_WIDTH-1:0];

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      axis_out_tvalid[c] = ~ej_empty & (head_ch == CHW'(c));
  end

  // Each popped slot is returned to the router one cycle later.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) credit_out <= 1'b0;
    else        credit_out <= ej_pop;
  end

`ifdef NOC_EP_PERF_CNT_EN
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      perf_inj_flits <= '0;
      perf_ej_flits  <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (xfer && grant_ch == CHW'(c))  perf_inj_flits[c] <= perf_inj_flits[c] + 32'd1;
        if (ej_pop && head_ch == CHW'(c)) perf_ej_flits[c]  <= perf_ej_flits[c] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_noc_multi_endpoint.sv
// tb/tb_axis_noc_multi_endpoint.sv - scoreboard bench for axis_noc_multi_endpoint
module tb_axis_noc_multi_endpoint;

  localparam int NC = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  localparam int TW = 2;
  localparam int EW = 4;
  localparam int FD = 2;

  logic clk_noc = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_noc = ~clk_noc;

  logic [0:NC-1]          axis_in_tvalid, axis_in_tready, axis_in_tlast;
  logic [0:NC-1][DW-1:0]  axis_in_tdata;
  logic [0:NC-1][IW-1:0]  axis_in_tid;
  logic [0:NC-1][TW-1:0]  axis_in_tdest;
  logic [0:NC-1]          axis_out_tvalid, axis_out_tready;
  logic [DW-1:0]          axis_out_tdata, data_out, data_in;
  logic                   axis_out_tlast, is_tail_out, send_out, credit_in;
  logic [IW-1:0]          axis_out_tid;
  logic [TW-1:0]          axis_out_tdest;
  logic [EW-1:0]          dest_out, dest_in;
  logic                   is_tail_in, send_in, credit_out;
  logic                   err_credit_overflow, err_eject_overflow;
  logic                   credit_man = 1'b0, credit_auto = 1'b0, auto_credit = 1'b0;

  assign credit_in = credit_man | credit_auto;

  axis_noc_multi_endpoint #(
    .NUM_CHANNELS(NC), .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(TW),
    .DEST_WIDTH(EW), .FLIT_BUFFER_DEPTH(FD)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(credit_out),
    .err_credit_overflow(err_credit_overflow), .err_eject_overflow(err_eject_overflow)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail;
  } inj_t;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail;
    int          ch;
  } ej_t;

  inj_t inj_q[$];
  ej_t  ej_q[$];
  inj_t ie;
  ej_t  ee;
  int   checks = 0;
  int   failures = 0;
  int   credit_pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_inj(input logic [63:0] d, input logic [3:0] dest, input logic tail);
    inj_t e;
    e.data = d; e.dest = dest; e.tail = tail;
    inj_q.push_back(e);
  endtask

  task automatic exp_ej(input logic [63:0] d, input logic [3:0] dest, input logic tail, input int ch);
    ej_t e;
    e.data = d; e.dest = dest; e.tail = tail; e.ch = ch;
    ej_q.push_back(e);
  endtask

  // Injection monitor: every flit the DUT sends to the router must match the next expected flit.
  always @(negedge clk_noc) begin
    if (rst_n === 1'b1 && send_out === 1'b1) begin
      if (inj_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL inj_unexpected actual=0x%0h required=none", data_out);
      end else begin
        ie = inj_q.pop_front();
        chk("inj_data", data_out, ie.data);
        chk("inj_dest", 64'(dest_out), 64'(ie.dest));
        chk("inj_tail", 64'(is_tail_out), 64'(ie.tail));
      end
    end
  end

  // Ejection monitor: checks each accepted AXIS output beat and the channel it appeared on.
  always @(negedge clk_noc) begin
    if (rst_n === 1'b1) begin
      if (credit_out === 1'b1) credit_pulses++;
      for (int c = 0; c < NC; c++) begin
        if (axis_out_tvalid[c] === 1'b1 && axis_out_tready[c] === 1'b1) begin
          if (ej_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ej_unexpected actual=0x%0h required=none", axis_out_tdata);
          end else begin
            ee = ej_q.pop_front();
            chk("ej_data", axis_out_tdata, ee.data);
            chk("ej_tid_tdest", 64'({axis_out_tid, axis_out_tdest}), 64'(ee.dest));
            chk("ej_tlast", 64'(axis_out_tlast), 64'(ee.tail));
            chk("ej_channel", 64'(c), 64'(ee.ch));
          end
        end
      end
    end
  end

  // Router model: return one credit the cycle after each flit it receives.
  always @(posedge clk_noc) begin
    #1;
    credit_auto = auto_credit & send_out & rst_n;
  end

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic clear_inputs();
    axis_in_tvalid = '0; axis_in_tlast = '0; axis_in_tdata = '0;
    axis_in_tid = '0; axis_in_tdest = '0; axis_out_tready = '0;
    data_in = '0; dest_in = '0; is_tail_in = 1'b0; send_in = 1'b0;
    credit_man = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_flit(input int ch, input logic [63:0] d, input logic [1:0] tid,
                           input logic [1:0] tdest, input logic last);
    bit ok;
    axis_in_tdata[ch] = d; axis_in_tid[ch] = tid; axis_in_tdest[ch] = tdest;
    axis_in_tlast[ch] = last; axis_in_tvalid[ch] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_noc);
      if (axis_in_tready[ch] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL inj_timeout actual=tready_low required=tready_high ch=%0d", ch);
    end
    tick();
    axis_in_tvalid[ch] = 1'b0;
  endtask

  task automatic send_pkt(input int ch, input int n, input logic [1:0] tid,
                          input logic [1:0] tdest, input logic [63:0] base);
    for (int i = 0; i < n; i++) send_flit(ch, base + 64'(i), tid, tdest, i == n - 1);
  endtask

  task automatic push_flit(input logic [63:0] d, input logic [3:0] dest, input logic tail);
    data_in = d; dest_in = dest; is_tail_in = tail; send_in = 1'b1;
    tick();
    send_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    auto_credit = 1'b1;
    #2;
    // Reset with a single-flit packet already waiting on channel 0.
    rst_n = 1'b0;
    axis_in_tdata[0] = 64'hA5; axis_in_tid[0] = 2'd0; axis_in_tdest[0] = 2'd1;
    axis_in_tlast[0] = 1'b1; axis_in_tvalid[0] = 1'b1;
    repeat (3) @(posedge clk_noc);
    @(negedge clk_noc);
    chk("rst_send_out", 64'(send_out), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_dest_tail", 64'({dest_out, is_tail_out, credit_out}), 64'd0);
    chk("rst_errors", 64'({err_credit_overflow, err_eject_overflow}), 64'd0);
    chk("rst_axis_out", 64'({axis_out_tvalid, axis_out_tlast, axis_out_tid, axis_out_tdest}), 64'd0);
    chk("rst_axis_out_tdata", axis_out_tdata, 64'd0);
    chk("rst_tready", 64'(axis_in_tready), 64'd0);
    exp_inj(64'hA5, 4'b0001, 1'b1);
    tick();
    rst_n = 1'b1;
    @(negedge clk_noc);
    chk("tready_after_reset", 64'(axis_in_tready), 64'(4'b1000));
    tick();
    axis_in_tvalid[0] = 1'b0;
    chk("send_out_latency", 64'(send_out), 64'd1);
    tick();
    chk("send_out_idle", 64'(send_out), 64'd0);
    repeat (2) tick();

    // Single three-flit packet on channel 2.
    exp_inj(64'h2000, 4'b0111, 1'b0);
    exp_inj(64'h2001, 4'b0111, 1'b0);
    exp_inj(64'h2002, 4'b0111, 1'b1);
    send_pkt(2, 3, 2'd1, 2'd3, 64'h2000);
    repeat (4) tick();
    chk("single_pkt_drained", 64'(inj_q.size()), 64'd0);

    // Contention from reset: channel 0 wins whole, then channel 1, then the pointer favours channel 2.
    do_reset();
    for (int i = 0; i < 4; i++) exp_inj(64'h100 + 64'(i), 4'b0000, i == 3);
    for (int i = 0; i < 4; i++) exp_inj(64'h200 + 64'(i), 4'b0110, i == 3);
    fork
      send_pkt(0, 4, 2'd0, 2'd0, 64'h100);
      send_pkt(1, 4, 2'd1, 2'd2, 64'h200);
    join
    exp_inj(64'h300, 4'b1000, 1'b1);
    exp_inj(64'h400, 4'b0011, 1'b1);
    fork
      send_flit(0, 64'h400, 2'd0, 2'd3, 1'b1);
      send_flit(2, 64'h300, 2'd2, 2'd0, 1'b1);
    join
    repeat (4) tick();
    chk("contention_drained", 64'(inj_q.size()), 64'd0);

    // Credit stall with the router holding back credits.
    auto_credit = 1'b0;
    repeat (2) tick();
    do_reset();
    for (int i = 0; i < 5; i++) exp_inj(64'h500 + 64'(i), 4'b1101, i == 4);
    axis_in_tid[3] = 2'd3; axis_in_tdest[3] = 2'd1; axis_in_tlast[3] = 1'b0;
    axis_in_tdata[3] = 64'h500; axis_in_tvalid[3] = 1'b1;
    @(negedge clk_noc);
    chk("stall_credit1", 64'(axis_in_tready[3]), 64'd1);
    tick();
    axis_in_tdata[3] = 64'h501;
    @(negedge clk_noc);
    chk("stall_credit2", 64'(axis_in_tready[3]), 64'd1);
    tick();
    axis_in_tdata[3] = 64'h502;
    @(negedge clk_noc);
    chk("stall_tready_drop", 64'(axis_in_tready[3]), 64'd0);
    repeat (3) tick();
    @(negedge clk_noc);
    chk("stall_hold", 64'(axis_in_tready[3]), 64'd0);
    tick();
    credit_man = 1'b1;
    @(negedge clk_noc);
    chk("stall_credit_cycle", 64'(axis_in_tready[3]), 64'd0);
    tick();
    credit_man = 1'b0;
    @(negedge clk_noc);
    chk("stall_release", 64'(axis_in_tready[3]), 64'd1);
    tick();
    axis_in_tdata[3] = 64'h503;
    @(negedge clk_noc);
    chk("stall_one_flit_only", 64'(axis_in_tready[3]), 64'd0);
    tick();
    credit_man = 1'b1;
    tick();
    @(negedge clk_noc);
    chk("coincide_pre", 64'(axis_in_tready[3]), 64'd1);
    tick();
    credit_man = 1'b0;
    axis_in_tdata[3] = 64'h504; axis_in_tlast[3] = 1'b1;
    @(negedge clk_noc);
    chk("coincide_unchanged", 64'(axis_in_tready[3]), 64'd1);
    tick();
    axis_in_tvalid[3] = 1'b0;
    @(negedge clk_noc);
    chk("stall_credits_empty", 64'(axis_in_tready[3]), 64'd0);
    repeat (3) tick();
    chk("stall_drained", 64'(inj_q.size()), 64'd0);

    // Ejection demux with head-of-line blocking and overflow drop.
    do_reset();
    credit_pulses = 0;
    exp_ej(64'h0E1, 4'b0110, 1'b1, 1);
    exp_ej(64'h0E0, 4'b0001, 1'b0, 0);
    push_flit(64'h0E1, 4'b0110, 1'b1);
    push_flit(64'h0E0, 4'b0001, 1'b0);
    @(negedge clk_noc);
    chk("hol_tvalid", 64'(axis_out_tvalid), 64'(4'b0100));
    chk("hol_tid", 64'(axis_out_tid), 64'd1);
    chk("hol_tdata", axis_out_tdata, 64'h0E1);
    tick();
    chk("eject_err_before", 64'(err_eject_overflow), 64'd0);
    push_flit(64'h0E2, 4'b0000, 1'b1);
    chk("eject_overflow_set", 64'(err_eject_overflow), 64'd1);
    axis_out_tready = 4'b0100;
    tick();
    chk("credit_out_after_pop", 64'(credit_out), 64'd1);
    chk("next_head_tvalid", 64'(axis_out_tvalid), 64'(4'b1000));
    axis_out_tready = 4'b0000;
    tick();
    chk("credit_out_single", 64'(credit_out), 64'd0);
    axis_out_tready = 4'b1000;
    tick();
    chk("credit_out_second", 64'(credit_out), 64'd1);
    chk("eject_empty", 64'(axis_out_tvalid), 64'd0);
    tick();
    chk("credit_pulse_count", 64'(credit_pulses), 64'd2);
    chk("eject_drained", 64'(ej_q.size()), 64'd0);

    // Sticky errors: cleared by reset, credit overflow, legal push+pop while full.
    do_reset();
    chk("errors_cleared", 64'({err_credit_overflow, err_eject_overflow}), 64'd0);
    credit_man = 1'b1;
    tick();
    credit_man = 1'b0;
    chk("credit_overflow_set", 64'(err_credit_overflow), 64'd1);
    exp_ej(64'hF0, 4'b1100, 1'b0, 3);
    exp_ej(64'hF1, 4'b1100, 1'b0, 3);
    exp_ej(64'hF2, 4'b1100, 1'b1, 3);
    push_flit(64'hF0, 4'b1100, 1'b0);
    push_flit(64'hF1, 4'b1100, 1'b0);
    axis_out_tready = 4'b0001;
    push_flit(64'hF2, 4'b1100, 1'b1);
    chk("full_push_pop_legal", 64'(err_eject_overflow), 64'd0);
    repeat (4) tick();
    chk("full_push_pop_drained", 64'(ej_q.size()), 64'd0);
    chk("credit_overflow_sticky", 64'(err_credit_overflow), 64'd1);
    do_reset();
    chk("errors_reset_again", 64'({err_credit_overflow, err_eject_overflow}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_noc_multi_endpoint.md
Name: axis_noc_multi_endpoint

Overview:
- Single-clock NoC endpoint that attaches NUM_CHANNELS independent AXI-stream users to one router local port (port 0).
- Injection side:
  - Packet-atomic round-robin arbitration across channels.
  - Credit-based flow control into the router's input buffer.
- Ejection side:
  - Shared flit buffer.
  - Demultiplexes flits to channels by the low bits of tid.
- Successor to the single-user shim-based local port: adds channel count, arbitration, credit tracking and error reporting.

Parameters:
- NUM_CHANNELS, 4, number of AXIS user channels; power of 2, 1..2**TID_WIDTH.
- TDATA_WIDTH, 64, AXIS data width; equals the flit width (no serialization).
- TID_WIDTH, 2, tid width.
- TDEST_WIDTH, 2, tdest width.
- DEST_WIDTH, TID_WIDTH+TDEST_WIDTH, flit dest field = {tid, tdest}.
- FLIT_BUFFER_DEPTH, 2, router input buffer depth; initial injection credits; ejection buffer depth.

Ports:
- clk_noc  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- axis_in_tvalid  in  [0:NUM_CHANNELS-1]  per-channel valid.
- axis_in_tready  out  [0:NUM_CHANNELS-1]  per-channel ready.
- axis_in_tdata  in  [0:NUM_CHANNELS-1][TDATA_WIDTH]  data.
- axis_in_tlast  in  [0:NUM_CHANNELS-1]  end of packet.
- axis_in_tid  in  [0:NUM_CHANNELS-1][TID_WIDTH]  tid.
- axis_in_tdest  in  [0:NUM_CHANNELS-1][TDEST_WIDTH]  tdest.
- axis_out_tvalid  out  [0:NUM_CHANNELS-1]  valid.
- axis_out_tready  in  [0:NUM_CHANNELS-1]  ready.
- axis_out_tdata  out  [TDATA_WIDTH]  shared data bus.
- axis_out_tlast  out  1  shared last.
- axis_out_tid  out  [TID_WIDTH]  shared tid.
- axis_out_tdest  out  [TDEST_WIDTH]  shared tdest.
- data_out  out  [TDATA_WIDTH]  flit to router.
- dest_out  out  [DEST_WIDTH]  flit dest to router.
- is_tail_out  out  1  flit is tail.
- send_out  out  1  flit valid to router.
- credit_in  in  1  credit pulse from router.
- data_in  in  [TDATA_WIDTH]  flit from router.
- dest_in  in  [DEST_WIDTH]  flit dest from router.
- is_tail_in  in  1  tail from router.
- send_in  in  1  flit valid from router.
- credit_out  out  1  credit pulse to router.
- err_credit_overflow  out  1  sticky error.
- err_eject_overflow  out  1  sticky error.

Behaviour:
- Reset: asserting rst_n low forces immediately, at any point including mid-packet:
  - all outputs 0;
  - credits = FLIT_BUFFER_DEPTH;
  - ejection buffer empty;
  - arbiter in IDLE with RR pointer 0;
  - errors cleared.
- Injection arbiter FSM:
  - IDLE: grant goes to the first valid channel at or after the RR pointer (wrapping at NUM_CHANNELS-1 -> 0). Go to LOCKED(ch).
    - If the granted flit is itself tlast and accepted in the same cycle, stay IDLE and advance the pointer.
  - LOCKED(ch): only ch may transfer. On an accepted tlast flit, pointer = ch+1 (mod NUM_CHANNELS) and go to IDLE.
  - Grant is computed combinationally, so the first flit can be accepted in the grant cycle.
- axis_in_tready[c] = granted(c) & (credits != 0). Ungranted channels see 0.
- Transfer = tvalid & tready. On a transfer, next cycle:
  - send_out = 1;
  - data_out = tdata;
  - dest_out = {tid, tdest};
  - is_tail_out = tlast.
  - Latency is 1 cycle. send_out is 0 in cycles without a transfer; payload outputs hold their value.
- Credit counter, width $clog2(FLIT_BUFFER_DEPTH+1):
  - transfer only: -1;
  - credit_in only: +1;
  - both in the same cycle: unchanged.
  - credit_in while counter == FLIT_BUFFER_DEPTH: counter saturates and err_credit_overflow is set.
- Ejection buffer: FIFO, depth FLIT_BUFFER_DEPTH, each entry {data, dest, tail}.
  - send_in pushes.
  - Push while full (with no pop that cycle): flit dropped and err_eject_overflow is set.
  - Push and pop in the same cycle while full: legal.
- Head channel hc = head tid[$clog2(NUM_CHANNELS)-1:0]. For NUM_CHANNELS=1, hc = 0.
  - axis_out_tvalid[c] = !empty & (c == hc).
  - Shared payload buses always carry the head entry: tid = dest[DEST_WIDTH-1:TDEST_WIDTH], tdest = dest[TDEST_WIDTH-1:0].
  - A pop happens on axis_out_tvalid[hc] & axis_out_tready[hc].
  - Head-of-line blocking across channels is accepted behaviour.
- credit_out: registered 1-cycle pulse on the cycle after each pop; exactly one pulse per popped flit.

Optional Feature:
- Macro: NOC_EP_PERF_CNT_EN.
- Defined: adds output ports perf_inj_flits and perf_ej_flits, each [0:NUM_CHANNELS-1][31:0].
  - Per-channel free-running counters of injected and ejected flits.
  - Wrap at 2**32; cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package noc_ep_pkg holds:
  - typedef arb_state_e {IDLE, LOCKED};
  - typedef flit_t struct {data, dest, tail};
  - function chan_of(dest).
- Sub-module: noc_ep_flit_fifo, a synchronous FIFO with full/empty, simultaneous push/pop and an overflow flag. Used for the ejection buffer.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. All outputs 0, credits=2; with ch0 tvalid=1, axis_in_tready[0]=1 in the first cycle after release.
- Single packet: ch2 sends 3 flits, tid=1, tdest=3. send_out follows each accepted flit by 1 cycle; dest_out=4'b0111; is_tail_out only on flit 3.
- Contention: ch0 and ch1 both send 4-flit packets from reset. Output order is all of ch0, then all of ch1, with no interleaving; the next grant goes to ch2 if it is valid.
- Credit stall (FLIT_BUFFER_DEPTH=2, credit_in withheld): exactly 2 flits leave and tready drops. One credit_in pulse releases exactly 1 more flit. credit_in coinciding with a transfer leaves credits unchanged.
- Ejection demux and HOL: push flit tid=1, then flit tid=0, with axis_out_tready[1]=0. Only axis_out_tvalid[1] is high and the tid=0 flit waits. Raising ready[1] pops it, credit_out pulses 1 cycle later, then axis_out_tvalid[0] rises.
- Errors: a third send_in with the buffer full and no pop sets err_eject_overflow. credit_in at full credits sets err_credit_overflow. Both clear only on reset.
